// File: rtl/hazard_track.sv
// hazard_track: D-stage decode with E/M/W destination and Tnew tracking.
// Define MDU_STALL_EN to add mult/div decode, the busy counter and MD stalls.
module hazard_track #(
  parameter logic [4:0] RA_REG = 5'd31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_D,
  output logic        stall,
  output logic [4:0]  A1_E,
  output logic [4:0]  A2_E,
  output logic [4:0]  A2_M,
  output logic [4:0]  A3_E,
  output logic [4:0]  A3_M,
  output logic [4:0]  A3_W,
  output logic        RegWr_E,
  output logic        RegWr_M,
  output logic        RegWr_W,
  output logic [1:0]  Tnew_E,
  output logic [1:0]  Tnew_M,
  output logic        md_busy
);

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_JAL     = 6'h03;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;
`ifdef MDU_STALL_EN
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1a;
  localparam logic [5:0] FN_MFHI = 6'h10;
  localparam logic [5:0] FN_MTHI = 6'h11;
  localparam logic [5:0] FN_MFLO = 6'h12;
  localparam logic [5:0] FN_MTLO = 6'h13;
  localparam logic [3:0] MUL_LAT = 4'd5;
  localparam logic [3:0] DIV_LAT = 4'd10;
`endif

  // Tuse of 3 exceeds any Tnew, so it can never stall
  localparam logic [1:0] TUSE_NONE = 2'd3;

  logic [5:0] op;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic       unused_shamt;

  assign op = instr_D[31:26];
  assign fn = instr_D[5:0];
  assign rs = instr_D[25:21];
  assign rt = instr_D[20:16];
  assign rd = instr_D[15:11];
  assign unused_shamt = ^instr_D[10:6];

  logic is_sp;
  logic is_addu;
  logic is_subu;
  logic is_jr;
  logic is_ori;
  logic is_lui;
  logic is_lw;
  logic is_sw;
  logic is_beq;
  logic is_jal;

  assign is_sp   = (op == OP_SPECIAL);
  assign is_addu = is_sp && (fn == FN_ADDU);
  assign is_subu = is_sp && (fn == FN_SUBU);
  assign is_jr   = is_sp && (fn == FN_JR);
  assign is_ori  = (op == OP_ORI);
  assign is_lui  = (op == OP_LUI);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_beq  = (op == OP_BEQ);
  assign is_jal  = (op == OP_JAL);

`ifdef MDU_STALL_EN
  logic is_mult;
  logic is_div;
  logic is_mfhi;
  logic is_mflo;
  logic is_mthi;
  logic is_mtlo;

  assign is_mult = is_sp && (fn == FN_MULT);
  assign is_div  = is_sp && (fn == FN_DIV);
  assign is_mfhi = is_sp && (fn == FN_MFHI);
  assign is_mflo = is_sp && (fn == FN_MFLO);
  assign is_mthi = is_sp && (fn == FN_MTHI);
  assign is_mtlo = is_sp && (fn == FN_MTLO);
`endif

  // D-stage record decoded from instr_D
  logic [4:0] a3_dec;
  logic       wr_dec;
  logic [1:0] tnew_dec;
  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
`ifdef MDU_STALL_EN
  logic       md_cls;
  logic       md_mul;
  logic       md_div;
`endif

  // Decode destination, write enable, Tnew and Tuse per operand
  always_comb begin
    a3_dec   = 5'd0;
    wr_dec   = 1'b0;
    tnew_dec = 2'd0;
    tuse_rs  = TUSE_NONE;
    tuse_rt  = TUSE_NONE;
`ifdef MDU_STALL_EN
    md_cls   = 1'b0;
    md_mul   = 1'b0;
    md_div   = 1'b0;
`endif
    unique case (1'b1)
      is_addu, is_subu: begin
        a3_dec   = rd;
        wr_dec   = 1'b1;
        tnew_dec = 2'd1;
        tuse_rs  = 2'd1;
        tuse_rt  = 2'd1;
      end
      is_ori: begin
        a3_dec   = rt;
        wr_dec   = 1'b1;
        tnew_dec = 2'd1;
        tuse_rs  = 2'd1;
      end
      is_lui: begin
        a3_dec   = rt;
        wr_dec   = 1'b1;
        tnew_dec = 2'd1;
      end
      is_lw: begin
        a3_dec   = rt;
        wr_dec   = 1'b1;
        tnew_dec = 2'd2;
        tuse_rs  = 2'd1;
      end
      is_sw: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd2;
      end
      is_beq: begin
        tuse_rs = 2'd0;
        tuse_rt = 2'd0;
      end
      is_jr: begin
        tuse_rs = 2'd0;
      end
      is_jal: begin
        a3_dec   = RA_REG;
        wr_dec   = 1'b1;
        tnew_dec = 2'd0;
      end
`ifdef MDU_STALL_EN
      is_mult, is_div: begin
        tuse_rs = 2'd1;
        tuse_rt = 2'd1;
        md_cls  = 1'b1;
        md_mul  = is_mult;
        md_div  = is_div;
      end
      is_mfhi, is_mflo: begin
        a3_dec   = rd;
        wr_dec   = 1'b1;
        tnew_dec = 2'd1;
        md_cls   = 1'b1;
      end
      is_mthi, is_mtlo: begin
        tuse_rs = 2'd1;
        md_cls  = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

  // Stage registers
  logic [4:0] a1_e_q, a1_e_d;
  logic [4:0] a2_e_q, a2_e_d;
  logic [4:0] a3_e_q, a3_e_d;
  logic       wr_e_q, wr_e_d;
  logic [1:0] tnew_e_q, tnew_e_d;
  logic [4:0] a2_m_q, a2_m_d;
  logic [4:0] a3_m_q, a3_m_d;
  logic       wr_m_q, wr_m_d;
  logic [1:0] tnew_m_q, tnew_m_d;
  logic [4:0] a3_w_q, a3_w_d;
  logic       wr_w_q, wr_w_d;

  // Operand hazards against E and M producers; A3 = 0 is filtered
  logic e_live;
  logic m_live;
  logic hz_rs;
  logic hz_rt;
  logic hz_md;

  assign e_live = wr_e_q && (a3_e_q != 5'd0);
  assign m_live = wr_m_q && (a3_m_q != 5'd0);

  assign hz_rs =
    (e_live && (rs == a3_e_q) && (tuse_rs < tnew_e_q)) ||
    (m_live && (rs == a3_m_q) && (tuse_rs < tnew_m_q));
  assign hz_rt =
    (e_live && (rt == a3_e_q) && (tuse_rt < tnew_e_q)) ||
    (m_live && (rt == a3_m_q) && (tuse_rt < tnew_m_q));

`ifdef MDU_STALL_EN
  logic       md_mul_e_q, md_mul_e_d;
  logic       md_div_e_q, md_div_e_d;
  logic [3:0] md_cnt_q, md_cnt_d;

  assign md_busy = (md_cnt_q != 4'd0) || md_mul_e_q || md_div_e_q;
  assign hz_md   = md_cls && md_busy;

  // Busy counter loads as a mult/div leaves E, then counts down
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_mul_e_q) begin
      md_cnt_d = MUL_LAT;
    end else if (md_div_e_q) begin
      md_cnt_d = DIV_LAT;
    end else if (md_cnt_q != 4'd0) begin
      md_cnt_d = md_cnt_q - 4'd1;
    end
  end
`else
  assign md_busy = 1'b0;
  assign hz_md   = 1'b0;
`endif

  assign stall = hz_rs || hz_rt || hz_md;

  // E takes the D record, or a bubble while stalled
  always_comb begin
    a1_e_d   = rs;
    a2_e_d   = rt;
    a3_e_d   = a3_dec;
    wr_e_d   = wr_dec;
    tnew_e_d = tnew_dec;
`ifdef MDU_STALL_EN
    md_mul_e_d = md_mul;
    md_div_e_d = md_div;
`endif
    if (stall) begin
      a1_e_d   = 5'd0;
      a2_e_d   = 5'd0;
      a3_e_d   = 5'd0;
      wr_e_d   = 1'b0;
      tnew_e_d = 2'd0;
`ifdef MDU_STALL_EN
      md_mul_e_d = 1'b0;
      md_div_e_d = 1'b0;
`endif
    end
  end

  // M and W advance unconditionally; Tnew ages by one, floor 0
  always_comb begin
    a2_m_d   = a2_e_q;
    a3_m_d   = a3_e_q;
    wr_m_d   = wr_e_q;
    tnew_m_d = (tnew_e_q == 2'd0) ? 2'd0 : tnew_e_q - 2'd1;
    a3_w_d   = a3_m_q;
    wr_w_d   = wr_m_q;
  end

  // Stage register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      a1_e_q   <= 5'd0;
      a2_e_q   <= 5'd0;
      a3_e_q   <= 5'd0;
      wr_e_q   <= 1'b0;
      tnew_e_q <= 2'd0;
      a2_m_q   <= 5'd0;
      a3_m_q   <= 5'd0;
      wr_m_q   <= 1'b0;
      tnew_m_q <= 2'd0;
      a3_w_q   <= 5'd0;
      wr_w_q   <= 1'b0;
    end else begin
      a1_e_q   <= a1_e_d;
      a2_e_q   <= a2_e_d;
      a3_e_q   <= a3_e_d;
      wr_e_q   <= wr_e_d;
      tnew_e_q <= tnew_e_d;
      a2_m_q   <= a2_m_d;
      a3_m_q   <= a3_m_d;
      wr_m_q   <= wr_m_d;
      tnew_m_q <= tnew_m_d;
      a3_w_q   <= a3_w_d;
      wr_w_q   <= wr_w_d;
    end
  end

`ifdef MDU_STALL_EN
  // Mult/div tracking in E and the busy counter
  always_ff @(posedge clk) begin
    if (reset) begin
      md_mul_e_q <= 1'b0;
      md_div_e_q <= 1'b0;
      md_cnt_q   <= 4'd0;
    end else begin
      md_mul_e_q <= md_mul_e_d;
      md_div_e_q <= md_div_e_d;
      md_cnt_q   <= md_cnt_d;
    end
  end
`endif

  assign A1_E    = a1_e_q;
  assign A2_E    = a2_e_q;
  assign A2_M    = a2_m_q;
  assign A3_E    = a3_e_q;
  assign A3_M    = a3_m_q;
  assign A3_W    = a3_w_q;
  assign RegWr_E = wr_e_q;
  assign RegWr_M = wr_m_q;
  assign RegWr_W = wr_w_q;
  assign Tnew_E  = tnew_e_q;
  assign Tnew_M  = tnew_m_q;

endmodule
